// File: rtl/resize_hls_axis_mibs_arb.sv
// Shares one pipelined signed(20) x unsigned(8) multiplier among N_REQ requesters.
// Define MIBS_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority (default: round-robin).
module resize_hls_axis_mibs_arb #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*20-1:0] req_a,
  input  logic [N_REQ*8-1:0]  req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [27:0]         rsp_p,
  output logic                mul_ce,
  output logic [19:0]         mul_din0,
  output logic [7:0]          mul_din1,
  input  logic [27:0]         mul_dout,
  output logic                busy
);

  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];
  logic [ID_W-1:0]    tag_id_d [MUL_LAT];
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic               stall;
`ifndef MIBS_ARB_STRICT_PRIO_EN
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

  // Only a real result whose owner is not ready can freeze the shared pipe.
  assign stall  = tag_v_q[MUL_LAT-1] & ~rsp_ready[tag_id_q[MUL_LAT-1]];
  assign mul_ce = ~stall;
  assign busy   = |tag_v_q;
  assign rsp_p  = mul_dout;

  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    sum       = '0;
    idx       = '0;
    if (mul_ce) begin
      for (int k = 0; k < N_REQ; k++) begin
`ifdef MIBS_ARB_STRICT_PRIO_EN
        sum = (ID_W+1)'(k);
`else
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
`endif
        idx = sum[ID_W-1:0];
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = idx;
        end
      end
      if (grant_any) req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && grant_id == ID_W'(i)) begin
        mul_din0 = req_a[20*i +: 20];
        mul_din1 = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = tag_v_q[MUL_LAT-1] && (tag_id_q[MUL_LAT-1] == ID_W'(i));
    end
  end

  always_comb begin
    tag_v_d  = tag_v_q;
    tag_id_d = tag_id_q;
    if (mul_ce) begin
      tag_v_d[0]  = grant_any;
      tag_id_d[0] = grant_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v_d[s]  = tag_v_q[s-1];
        tag_id_d[s] = tag_id_q[s-1];
      end
    end
  end

`ifndef MIBS_ARB_STRICT_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
  end
`endif

  // Tag pipe stage boundary: control state is reset, owner ids are plain data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v_q  <= '0;
`ifndef MIBS_ARB_STRICT_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      tag_v_q  <= tag_v_d;
`ifndef MIBS_ARB_STRICT_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
  end

endmodule

// File: tb/tb_resize_hls_axis_mibs_arb.sv
// Scoreboard bench for resize_hls_axis_mibs_arb with a two-stage ce-gated multiplier model.
module tb_resize_hls_axis_mibs_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready;
  logic [79:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  rsp_valid, rsp_ready;
  logic [27:0] rsp_p;
  logic        mul_ce;
  logic [19:0] mul_din0;
  logic [7:0]  mul_din1;
  logic [27:0] mul_dout;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int id; int p; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  resize_hls_axis_mibs_arb #(.N_REQ(4), .ID_W(2), .MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .busy(busy)
  );

  // Multiplier model: operand register then product register, both ce-gated.
  logic signed [19:0] m_a = '0;
  logic        [7:0]  m_b = '0;
  logic signed [27:0] m_p = '0;
  always @(posedge clk) begin
    if (mul_ce) begin
      m_a <= mul_din0;
      m_b <= mul_din1;
      m_p <= 28'(m_a * $signed({1'b0, m_b}));
    end
  end
  assign mul_dout = m_p;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int p);
    exp_t e;
    e.id = id;
    e.p  = p;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && ((rsp_valid & rsp_ready) != 4'b0)) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected_valid", int'(rsp_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_owner", int'(rsp_valid), 1 << e.id);
        chk("rsp_product", int'($signed(rsp_p)), e.p);
      end
    end
  end

  task automatic issue_op(input int id, input int a, input int b);
    int hs;
    hs = 0;
    req_a[20*id +: 20] = 20'(a);
    req_b[8*id +: 8]   = 8'(b);
    req_valid[id]      = 1'b1;
    for (int k = 0; k < 20 && hs == 0; k++) begin
      @(negedge clk);
      hs = int'(req_ready[id]);
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    chk("issue_handshake", hs, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && (exp_q.size() != 0 || busy); k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mul_ce", int'(mul_ce), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single op with latency check
    push(0, -200000);
    issue_op(0, -1000, 200);
    @(negedge clk);
    chk("lat_not_early", int'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_on_time", int'(rsp_valid), 1);
    wait_drain();

    // operand extremes
    push(0, -133693440);
    push(3, 133693185);
    issue_op(0, -524288, 255);
    issue_op(3, 524287, 255);
    wait_drain();

`ifndef MIBS_ARB_STRICT_PRIO_EN
    // round-robin fairness, pointer is at 0 here
    req_a = {20'(-1), 20'(100), 20'(-7), 20'(3)};
    req_b = {8'd255, 8'd2, 8'd11, 8'd5};
    push(0, 15); push(1, -77); push(2, 200); push(3, -255); push(0, 15); push(1, -77);
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", int'(req_ready), 1 << (k % 4));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    wait_drain();
`endif

    // backpressure on requester 1
    push(1, 12340); push(2, -150); push(2, -18);
    rsp_ready = 4'b1101;
    req_a[20 +: 20] = 20'(1234);
    req_b[8 +: 8]   = 8'd10;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_grant_req1", int'(req_ready), 2);
    @(posedge clk);
    #1;
    req_a[40 +: 20] = 20'(-50);
    req_b[16 +: 8]  = 8'd3;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_grant_req2", int'(req_ready), 4);
    @(posedge clk);
    #1;
    req_a[40 +: 20] = 20'(-2);
    req_b[16 +: 8]  = 8'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_mul_ce_low", int'(mul_ce), 0);
      chk("bp_no_grant", int'(req_ready), 0);
      chk("bp_rsp_p_held", int'($signed(rsp_p)), 12340);
      chk("bp_rsp_valid_held", int'(rsp_valid), 2);
      @(posedge clk);
      #1;
    end
    rsp_ready = 4'hF;
    @(negedge clk);
    chk("bp_resume_grant", int'(req_ready), 4);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();

    // reset with two ops in flight
    req_a[0 +: 20]  = 20'(7);
    req_b[0 +: 8]   = 8'd7;
    req_a[20 +: 20] = 20'(8);
    req_b[8 +: 8]   = 8'd8;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("rstmid_grant0", int'(req_ready), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmid_grant1", int'(req_ready), 2);
    chk("rstmid_busy_before", int'(busy), 1);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("rstmid_rsp_valid", int'(rsp_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_mul_ce", int'(mul_ce), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    req_a = {20'(4), 20'(3), 20'(2), 20'(5)};
    req_b = {8'd1, 8'd1, 8'd1, 8'd6};
    push(0, 30);
    req_valid = 4'hF;
    @(negedge clk);
    chk("post_reset_grant0", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_idle", int'(busy), 0);

`ifdef MIBS_ARB_STRICT_PRIO_EN
    // fixed priority: req0 beats req2 while valid
    req_a[0 +: 20]  = 20'(10);
    req_b[0 +: 8]   = 8'd10;
    req_a[40 +: 20] = 20'(-3);
    req_b[16 +: 8]  = 8'd4;
    push(0, 100); push(0, 100); push(0, 100); push(2, -12);
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio_req0", int'(req_ready), 1);
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0100;
    @(negedge clk);
    chk("prio_req2", int'(req_ready), 4);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
